thresh_pwm: RTL and testbench
=============================

THRESH_PWM -- requirements
Module: thresh_pwm

Interface
REQ-001 SHALL have port: clk  input  1  system clock; one clock only, also the AFE sample clock.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: VIH  input  8  requested high threshold, sampled on thresh_wrt.
REQ-004 SHALL have port: VIL  input  8  requested low threshold, sampled on thresh_wrt.
REQ-005 SHALL have port: thresh_wrt  input  1  one-cycle load strobe.
REQ-006 SHALL have port: VIH_PWM  output  1  registered PWM encoding the active VIH.
REQ-007 SHALL have port: VIL_PWM  output  1  registered PWM encoding the active VIL.
REQ-008 SHALL have port: settled  output  1  a full period has been emitted on the current active values.
REQ-009 SHALL have port: err  output  1  one-cycle pulse when a write is rejected.

Function
REQ-010 SHALL run a free 10-bit period counter cnt, 0..1023, wrapping 1023->0; period is 1024 clk.
REQ-011 SHALL use duty = {thresh,2'b10} (thresh*4+2), so a receiver counting high clocks and keeping bits [9:2] recovers thresh exactly with +/-1 clock margin.
REQ-012 SHALL drive VIx_PWM high in cycles where registered (cnt < duty_x) is true; output is a flop, one clk after the compare.
REQ-013 SHALL emit a rising and a falling edge every period for all 8-bit values (0x00 -> 2 high clocks, 0xFF -> 1022 high clocks).
REQ-014 SHALL latch VIH/VIL into pending registers on thresh_wrt and set a pend flag.
REQ-015 SHALL copy pending to active at cnt==1023 when pend is set, then clear pend; the new duty takes effect from cnt==0.
REQ-016 SHALL treat thresh_wrt coincident with cnt==1023 as going directly to active at that boundary.
REQ-017 SHALL keep only the last of multiple writes within one period (last wins).
REQ-018 SHALL reject thresh_wrt when VIL > VIH: no register change, pend/settled unchanged, err high for exactly one cycle; VIL == VIH is accepted.
REQ-019 SHALL clear settled on an accepted thresh_wrt and assert it at the second cnt==1023 boundary after the transfer, i.e. once one complete period on new values is out.
REQ-020 SHALL never change an active duty mid-period.

Reset
REQ-021 SHALL on rst_n low, immediately: cnt=0, active VIH=0xAA, active VIL=0x55, pending=defaults, pend=0, VIH_PWM=0, VIL_PWM=0, settled=0, err=0.
REQ-022 SHALL on reset mid-period abandon the period; first high output cycle is one clk after rst_n release.
REQ-023 SHALL assert settled at the first cnt==1023 after reset release, since defaults count as transferred.

Configuration
REQ-024 SHALL, with THRESH_PWM_PHASE_OFFSET_EN defined, compare VIL_PWM against (cnt+512) mod 1024, so VIL_PWM rises 512 clk after VIH_PWM; duty and transfer boundary are unchanged.
REQ-025 SHALL, without THRESH_PWM_PHASE_OFFSET_EN, make both outputs rise in the same clk.

Structure
REQ-026 SHALL place in package thresh_pwm_pkg: CNT_W=10, PERIOD=1024, DEF_VIH=8'hAA, DEF_VIL=8'h55, DUTY_LSB=2'b10, PHASE_OFS=512.
REQ-027 SHALL implement each channel as sub-module pwm10 (count-in, duty-in, registered compare output), instantiated twice.

Verification
REQ-028 SHALL check: reset then no write -> VIH_PWM high 682 of 1024 clk, VIL_PWM high 342; settled at first wrap; AFE model captures 0xAA/0x55.
REQ-029 SHALL check: wrt VIH=0xC0 VIL=0x40 at cnt=300 -> current period 682/342, next period 770/258, settled low until the second boundary; AFE model reads 0xC0/0x40.
REQ-030 SHALL check: wrt VIH=0xFF VIL=0x00 -> 1022/2 high clocks, both outputs toggle every period.
REQ-031 SHALL check: wrt VIH=0x80 VIL=0x90 -> err one-cycle pulse, outputs and settled unchanged.
REQ-032 SHALL check: writes 0x70/0x30 then 0x90/0x20 in one period -> only 0x90/0x20 applied; wrt at cnt==1023 applied at that boundary.
REQ-033 SHALL check: rst_n low at cnt=500 with new values active -> outputs 0 at once, defaults restored, period restarts at cnt=0.

Source files
------------

// File: rtl/thresh_pwm_pkg.sv
// Shared widths, reset defaults and duty encoding for the threshold PWM encoder.
package thresh_pwm_pkg;

  localparam int unsigned CNT_W     = 10;
  localparam int unsigned PERIOD    = 1024;
  localparam int unsigned TH_W      = 8;
  localparam int unsigned PHASE_OFS = 512;

  localparam logic [TH_W-1:0] DEF_VIH  = 8'hAA;
  localparam logic [TH_W-1:0] DEF_VIL  = 8'h55;
  localparam logic [1:0]      DUTY_LSB = 2'b10;

  typedef struct packed {
    logic [TH_W-1:0] vih;
    logic [TH_W-1:0] vil;
  } thresh_t;

  localparam thresh_t DEF_THRESH = '{vih: DEF_VIH, vil: DEF_VIL};

  // Half-LSB offset keeps the receiver's recovered bits [9:2] centred with +/-1 clk margin.
  function automatic logic [CNT_W-1:0] duty_of(input logic [TH_W-1:0] th);
    return {th, DUTY_LSB};
  endfunction

endpackage

// File: rtl/thresh_pwm_pwm10.sv
// One PWM channel: registered compare of the shared period count against a duty.
module pwm10
  import thresh_pwm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] duty,
  output logic             pwm
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm <= 1'b0;
    end else begin
      pwm <= (cnt < duty);
    end
  end

endmodule

// File: rtl/thresh_pwm.sv
// Encodes VIH/VIL thresholds as two 1024-clk PWM streams with period-aligned updates.
// Optional THRESH_PWM_PHASE_OFFSET_EN shifts the VIL channel by half a period.
module thresh_pwm
  import thresh_pwm_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [TH_W-1:0] VIH,
  input  logic [TH_W-1:0] VIL,
  input  logic            thresh_wrt,
  output logic            VIH_PWM,
  output logic            VIL_PWM,
  output logic            settled,
  output logic            err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_vil;
  thresh_t          act;
  thresh_t          pend_val;
  thresh_t          req;
  logic             pend;
  logic             armed;
  logic             boundary;
  logic             accept;

  assign req      = '{vih: VIH, vil: VIL};
  assign boundary = (cnt == CNT_LAST);
  assign accept   = thresh_wrt && (VIL <= VIH);

  // armed: values were transferred at the last boundary; settle after one more full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      act      <= DEF_THRESH;
      pend_val <= DEF_THRESH;
      pend     <= 1'b0;
      armed    <= 1'b1;
      settled  <= 1'b0;
      err      <= 1'b0;
    end else begin
      cnt <= cnt + CNT_W'(1);
      err <= thresh_wrt && !accept;
      if (boundary) begin
        if (accept) begin
          act      <= req;
          pend_val <= req;
          pend     <= 1'b0;
          settled  <= 1'b0;
          armed    <= 1'b1;
        end else if (pend) begin
          act   <= pend_val;
          pend  <= 1'b0;
          armed <= 1'b1;
        end else if (armed) begin
          settled <= 1'b1;
          armed   <= 1'b0;
        end
      end else if (accept) begin
        pend_val <= req;
        pend     <= 1'b1;
        settled  <= 1'b0;
        armed    <= 1'b0;
      end
    end
  end

`ifdef THRESH_PWM_PHASE_OFFSET_EN
  assign cnt_vil = cnt + CNT_W'(PHASE_OFS);
`else
  assign cnt_vil = cnt;
`endif

  pwm10 u_vih (
    .clk  (clk),
    .rst_n(rst_n),
    .cnt  (cnt),
    .duty (duty_of(act.vih)),
    .pwm  (VIH_PWM)
  );

  pwm10 u_vil (
    .clk  (clk),
    .rst_n(rst_n),
    .cnt  (cnt_vil),
    .duty (duty_of(act.vil)),
    .pwm  (VIL_PWM)
  );

endmodule

// File: tb/tb_thresh_pwm.sv
// Scoreboard bench for thresh_pwm: per-period high counts, AFE decode, settled and err.
module tb_thresh_pwm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       thresh_wrt = 1'b0;
  logic [7:0] vih = 8'h00;
  logic [7:0] vil = 8'h00;
  logic       vih_pwm, vil_pwm, settled, err;

  thresh_pwm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .VIH       (vih),
    .VIL       (vil),
    .thresh_wrt(thresh_wrt),
    .VIH_PWM   (vih_pwm),
    .VIL_PWM   (vil_pwm),
    .settled   (settled),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int l;
    bit st;
  } rec_t;

  rec_t sb_q[$];
  int   err_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   run = 1'b0;
  int   cur_h, cur_l, nxt_h, nxt_l;
  bit   wrote;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
  endtask

  // Reference model: values written during period P (last accepted wins) apply to P+1;
  // settled after period P ends iff no write was accepted during P.
  task automatic step(input bit w, input int h, input int l);
    int c;
    @(negedge clk);
    thresh_wrt = w;
    vih = 8'(h);
    vil = 8'(l);
    @(posedge clk);
    c = cyc % 1024;
    cyc++;
    if (w) begin
      if (l > h) err_q.push_back(cyc);
      else begin
        nxt_h = h;
        nxt_l = l;
        wrote = 1'b1;
        acc_q.push_back(cyc);
      end
    end
    if (c == 1023) begin
      sb_q.push_back('{cur_h, cur_l, !wrote});
      cur_h = nxt_h;
      cur_l = nxt_l;
      wrote = 1'b0;
    end
  endtask

  task automatic goto(input int p, input int c);
    while (cyc < p * 1024 + c) step(1'b0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run = 1'b0;
    thresh_wrt = 1'b0;
    #1;
    check("rst_vih_pwm", int'(vih_pwm), 0);
    check("rst_vil_pwm", int'(vil_pwm), 0);
    check("rst_settled", int'(settled), 0);
    check("rst_err", int'(err), 0);
    sb_q.delete();
    err_q.delete();
    acc_q.delete();
    cyc = 0;
    cur_h = 8'hAA; cur_l = 8'h55;
    nxt_h = 8'hAA; nxt_l = 8'h55;
    wrote = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    run = 1'b1;
  endtask

  // Monitor: sample c reflects the compare made at cnt c; a window closes after c==1023.
  int   hi_h, hi_l, rise_h, rise_l;
  logic prev_h, prev_l;
  bit   exp_e;
  rec_t r;

  always @(negedge clk) begin
    if (!run) begin
      hi_h = 0; hi_l = 0; rise_h = 0; rise_l = 0;
      prev_h = 1'b0; prev_l = 1'b0;
    end else if (cyc >= 1) begin
      hi_h += int'(vih_pwm);
      hi_l += int'(vil_pwm);
      if (vih_pwm && !prev_h) rise_h++;
      if (vil_pwm && !prev_l) rise_l++;
      prev_h = vih_pwm;
      prev_l = vil_pwm;
      exp_e = (err_q.size() > 0) && (err_q[0] == cyc);
      if (exp_e) void'(err_q.pop_front());
      if (exp_e || err) check("err_pulse", int'(err), int'(exp_e));
      if ((acc_q.size() > 0) && (acc_q[0] == cyc)) begin
        void'(acc_q.pop_front());
        check("settled_clr", int'(settled), 0);
      end
      if ((cyc - 1) % 1024 == 1023) begin
        if (sb_q.size() == 0) check("sb_underflow", sb_q.size(), 1);
        else begin
          r = sb_q.pop_front();
          check("vih_high_clks", hi_h, r.h * 4 + 2);
          check("vil_high_clks", hi_l, r.l * 4 + 2);
          check("afe_vih", hi_h >> 2, r.h);
          check("afe_vil", hi_l >> 2, r.l);
          check("vih_rises", rise_h, 1);
`ifndef THRESH_PWM_PHASE_OFFSET_EN
          check("vil_rises", rise_l, 1);
`endif
          check("settled_end", int'(settled), int'(r.st));
        end
        hi_h = 0; hi_l = 0; rise_h = 0; rise_l = 0;
      end
    end
  end

  initial begin
    int  c, h, l;
    bit  w;
    do_reset();
    goto(1, 300);  step(1'b1, 8'hC0, 8'h40);
    goto(3, 100);  step(1'b1, 8'h80, 8'h90);
    goto(4, 10);   step(1'b1, 8'hFF, 8'h00);
    goto(6, 200);  step(1'b1, 8'h70, 8'h30);
    goto(6, 600);  step(1'b1, 8'h90, 8'h20);
    goto(7, 1023); step(1'b1, 8'h50, 8'h50);
    goto(9, 0);
    while (cyc < 29 * 1024) begin
      c = cyc % 1024;
      w = ($urandom_range(299, 0) == 0) || (c == 1023 && $urandom_range(3, 0) == 0);
      h = int'($urandom_range(255, 0));
      l = ($urandom_range(1, 0) == 1) ? int'($urandom_range(h, 0)) : int'($urandom_range(255, 0));
      step(w, h, l);
    end
    goto(30, 100); step(1'b1, 8'hE0, 8'h10);
    goto(31, 500);
    do_reset();
    goto(2, 0);
    @(negedge clk);
    #1;
    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
